// File: rtl/soc_ifc_fw_upd_rst_req.sv
// Firmware-update reset request controller: latches the uC FW_UPDATE_RESET write, waits for
// quiescence, drives the boot FSM request level and tracks the reset back to BOOT_DONE.

package soc_ifc_fw_upd_pkg;

  typedef enum logic [2:0] {
    BOOT_IDLE   = 3'd0,
    BOOT_FUSE   = 3'd1,
    BOOT_FW_RST = 3'd2,
    BOOT_WAIT   = 3'd3,
    BOOT_DONE   = 3'd4
  } boot_fsm_state_e;

  typedef enum logic [2:0] {
    UPD_IDLE    = 3'd0,
    UPD_QUIESCE = 3'd1,
    UPD_DELAY   = 3'd2,
    UPD_ASSERT  = 3'd3,
    UPD_RECOVER = 3'd4
  } fw_upd_state_e;

endpackage

module soc_ifc_fw_upd_rst_req
  import soc_ifc_fw_upd_pkg::*;
#(
  parameter int unsigned PRE_DELAY      = 4,
  parameter int unsigned MIN_WAIT       = 5,
  parameter int unsigned DEFAULT_WAIT   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            cptra_noncore_rst_b,
  input  logic            req_wr_en,
  input  logic            req_wr_data,
  input  logic            wait_wr_en,
  input  logic [7:0]      wait_wr_data,
  input  logic            quiesce_ok,
  input  boot_fsm_state_e boot_fsm_ps,
  input  logic            fw_upd_rst_executed,
  output logic            fw_update_rst,
  output logic [7:0]      fw_update_rst_wait_cycles,
  output logic            busy,
  output logic            done_pulse,
  output logic            err_busy_wr,
  output logic            err_timeout,
  output logic [7:0]      fw_upd_cnt,
  output fw_upd_state_e   dbg_state
);

  localparam logic [3:0]  DLY_LOAD       = 4'(PRE_DELAY - 1);
  localparam logic [15:0] TMO_LAST       = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MIN_WAIT_L     = 8'(MIN_WAIT);
  localparam logic [7:0]  DEFAULT_WAIT_L = 8'(DEFAULT_WAIT);

  fw_upd_state_e state_q, state_d;
  logic [3:0]    dly_cnt_q, dly_cnt_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic          seen_not_done_q, seen_not_done_d;
  logic [7:0]    wait_cfg_q, wait_cfg_d;
  logic          done_pulse_q, done_pulse_d;
  logic          err_busy_wr_q, err_busy_wr_d;
  logic          err_timeout_q, err_timeout_d;
  logic [7:0]    fw_upd_cnt_q, fw_upd_cnt_d;

  logic req_set;
  logic boot_done;

  assign req_set   = req_wr_en & req_wr_data;
  assign boot_done = (boot_fsm_ps == BOOT_DONE);

  // State and datapath registers; everything lives in the noncore reset domain.
  always_ff @(posedge clk or negedge cptra_noncore_rst_b) begin
    if (!cptra_noncore_rst_b) begin
      state_q         <= UPD_IDLE;
      dly_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      seen_not_done_q <= 1'b0;
      wait_cfg_q      <= DEFAULT_WAIT_L;
      done_pulse_q    <= 1'b0;
      err_busy_wr_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
      fw_upd_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      dly_cnt_q       <= dly_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      seen_not_done_q <= seen_not_done_d;
      wait_cfg_q      <= wait_cfg_d;
      done_pulse_q    <= done_pulse_d;
      err_busy_wr_q   <= err_busy_wr_d;
      err_timeout_q   <= err_timeout_d;
      fw_upd_cnt_q    <= fw_upd_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UPD_IDLE: begin
        if (req_set) state_d = UPD_QUIESCE;
      end
      UPD_QUIESCE: begin
        if (quiesce_ok) state_d = UPD_DELAY;
      end
      UPD_DELAY: begin
        if (!quiesce_ok)          state_d = UPD_QUIESCE;
        else if (dly_cnt_q == '0) state_d = UPD_ASSERT;
      end
      UPD_ASSERT: begin
        // An acknowledge in the last budgeted cycle still counts as success.
        if (fw_upd_rst_executed)      state_d = UPD_RECOVER;
        else if (tmo_cnt_q == TMO_LAST) state_d = UPD_IDLE;
      end
      UPD_RECOVER: begin
        if (seen_not_done_q && boot_done) state_d = UPD_IDLE;
      end
      default: state_d = UPD_IDLE;
    endcase
  end

  always_comb begin
    dly_cnt_d       = dly_cnt_q;
    tmo_cnt_d       = '0;
    seen_not_done_d = seen_not_done_q;
    wait_cfg_d      = wait_cfg_q;
    done_pulse_d    = 1'b0;
    err_busy_wr_d   = 1'b0;
    err_timeout_d   = 1'b0;
    fw_upd_cnt_d    = fw_upd_cnt_q;

    if (state_q == UPD_QUIESCE && quiesce_ok) begin
      dly_cnt_d = DLY_LOAD;
    end else if (state_q == UPD_DELAY && quiesce_ok && dly_cnt_q != '0) begin
      dly_cnt_d = dly_cnt_q - 4'd1;
    end

    if (state_q == UPD_ASSERT && state_d == UPD_ASSERT) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    // The boot FSM must be seen leaving BOOT_DONE before a return to it means completion.
    if (state_q == UPD_ASSERT) begin
      seen_not_done_d = 1'b0;
    end else if (state_q == UPD_RECOVER && !boot_done) begin
      seen_not_done_d = 1'b1;
    end

    if (state_q == UPD_IDLE && wait_wr_en) begin
      wait_cfg_d = (wait_wr_data < MIN_WAIT_L) ? MIN_WAIT_L : wait_wr_data;
    end

    if (state_q != UPD_IDLE && (req_set || wait_wr_en)) begin
      err_busy_wr_d = 1'b1;
    end

    if (state_q == UPD_ASSERT && state_d == UPD_IDLE) begin
      err_timeout_d = 1'b1;
    end

    if (state_q == UPD_RECOVER && state_d == UPD_IDLE) begin
      done_pulse_d = 1'b1;
      if (fw_upd_cnt_q != 8'hFF) fw_upd_cnt_d = fw_upd_cnt_q + 8'd1;
    end
  end

  always_comb begin
    fw_update_rst = (state_q == UPD_ASSERT);
    busy          = (state_q != UPD_IDLE);
  end

  assign fw_update_rst_wait_cycles = wait_cfg_q;
  assign done_pulse                = done_pulse_q;
  assign err_busy_wr               = err_busy_wr_q;
  assign err_timeout               = err_timeout_q;
  assign fw_upd_cnt                = fw_upd_cnt_q;
  assign dbg_state                 = state_q;

`ifndef SYNTHESIS
  a_rst_implies_busy: assert property (@(posedge clk) disable iff (!cptra_noncore_rst_b)
    fw_update_rst |-> busy);
  a_wait_floor: assert property (@(posedge clk) disable iff (!cptra_noncore_rst_b)
    fw_update_rst_wait_cycles >= MIN_WAIT_L);
  a_pulse_excl: assert property (@(posedge clk) disable iff (!cptra_noncore_rst_b)
    !(done_pulse && err_timeout));
`endif

endmodule

// File: tb/tb_soc_ifc_fw_upd_rst_req.sv
// Bench for soc_ifc_fw_upd_rst_req: directed scenarios, a cycle-level behavioural model
// with a per-cycle compare, and hand-computed literal checks.

module tb_soc_ifc_fw_upd_rst_req;
  import soc_ifc_fw_upd_pkg::*;

  localparam int PRE_DELAY      = 4;
  localparam int MIN_WAIT       = 5;
  localparam int DEFAULT_WAIT   = 10;
  localparam int TIMEOUT_CYCLES = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            req_wr_en;
  logic            req_wr_data;
  logic            wait_wr_en;
  logic [7:0]      wait_wr_data;
  logic            quiesce_ok;
  boot_fsm_state_e boot_ps = BOOT_DONE;
  logic            executed;
  logic            fw_update_rst;
  logic [7:0]      wait_cycles;
  logic            busy;
  logic            done_pulse;
  logic            err_busy_wr;
  logic            err_timeout;
  logic [7:0]      fw_upd_cnt;
  fw_upd_state_e   dbg_state;

  soc_ifc_fw_upd_rst_req #(
    .PRE_DELAY(PRE_DELAY), .MIN_WAIT(MIN_WAIT),
    .DEFAULT_WAIT(DEFAULT_WAIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk                      (clk),
    .cptra_noncore_rst_b      (rst_n),
    .req_wr_en                (req_wr_en),
    .req_wr_data              (req_wr_data),
    .wait_wr_en               (wait_wr_en),
    .wait_wr_data             (wait_wr_data),
    .quiesce_ok               (quiesce_ok),
    .boot_fsm_ps              (boot_ps),
    .fw_upd_rst_executed      (executed),
    .fw_update_rst            (fw_update_rst),
    .fw_update_rst_wait_cycles(wait_cycles),
    .busy                     (busy),
    .done_pulse               (done_pulse),
    .err_busy_wr              (err_busy_wr),
    .err_timeout              (err_timeout),
    .fw_upd_cnt               (fw_upd_cnt),
    .dbg_state                (dbg_state)
  );

  // ---------------- boot FSM responder ----------------
  logic       boot_hold = 1'b0;
  logic [2:0] boot_cnt  = 3'd0;

  assign executed = fw_update_rst && (boot_ps == BOOT_DONE);

  always @(posedge clk) begin
    if (boot_hold) begin
      boot_ps  <= BOOT_WAIT;
      boot_cnt <= 3'd0;
    end else if (boot_ps == BOOT_DONE) begin
      if (executed) begin
        boot_ps  <= BOOT_FW_RST;
        boot_cnt <= 3'd3;
      end
    end else if (boot_cnt != 3'd0) begin
      boot_cnt <= boot_cnt - 3'd1;
    end else begin
      boot_ps <= BOOT_DONE;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int n_rise   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for PRE_DELAY+1 consecutive quiet samples,
  // 2 request raised, 3 waiting for the boot FSM round trip.
  int       m_phase;
  int       m_quiet_run;
  int       m_assert_cycles;
  bit       m_left_done;
  int       m_cfg;
  int       m_cnt;
  bit       e_done, e_busy_err, e_tmo;

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_quiet_run = 0; m_assert_cycles = 0; m_left_done = 0;
        m_cfg = DEFAULT_WAIT; m_cnt = 0;
        e_done = 0; e_busy_err = 0; e_tmo = 0;
      end else begin
        e_done = 0;
        e_tmo  = 0;
        e_busy_err = (m_phase != 0) && ((req_wr_en && req_wr_data) || wait_wr_en);
        case (m_phase)
          0: begin
            if (wait_wr_en) m_cfg = (int'(wait_wr_data) < MIN_WAIT) ? MIN_WAIT : int'(wait_wr_data);
            if (req_wr_en && req_wr_data) begin
              m_phase = 1;
              m_quiet_run = 0;
            end
          end
          1: begin
            if (quiesce_ok) begin
              m_quiet_run++;
              if (m_quiet_run == PRE_DELAY + 1) begin
                m_phase = 2;
                m_assert_cycles = 0;
              end
            end else begin
              m_quiet_run = 0;
            end
          end
          2: begin
            if (executed) begin
              m_phase = 3;
              m_left_done = 0;
            end else begin
              m_assert_cycles++;
              if (m_assert_cycles == TIMEOUT_CYCLES) begin
                m_phase = 0;
                e_tmo = 1;
              end
            end
          end
          default: begin
            if (m_left_done && boot_ps == BOOT_DONE) begin
              m_phase = 0;
              e_done = 1;
              if (m_cnt < 255) m_cnt++;
            end else if (boot_ps != BOOT_DONE) begin
              m_left_done = 1;
            end
          end
        endcase
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic cmp_loop();
    logic prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (fw_update_rst && !prev_rst) n_rise++;
      prev_rst = fw_update_rst;
      if (rst_n === 1'b1) begin
        check("m_fw_update_rst", 32'(fw_update_rst), 32'(m_phase == 2));
        check("m_busy",          32'(busy),          32'(m_phase != 0));
        check("m_wait_cycles",   32'(wait_cycles),   32'(m_cfg));
        check("m_done_pulse",    32'(done_pulse),    32'(e_done));
        check("m_err_busy_wr",   32'(err_busy_wr),   32'(e_busy_err));
        check("m_err_timeout",   32'(err_timeout),   32'(e_tmo));
        check("m_fw_upd_cnt",    32'(fw_upd_cnt),    32'(m_cnt));
        check("m_dbg_idle",      32'(dbg_state == UPD_IDLE), 32'(m_phase == 0));
      end
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic wait_wr(input logic [7:0] d);
    wait_wr_en = 1'b1; wait_wr_data = d;
    @(negedge clk);
    wait_wr_en = 1'b0; wait_wr_data = 8'd0;
  endtask

  // Raise a request (optionally with a wait write) and count negedges until fw_update_rst is seen.
  task automatic req_measure(input bit with_wait, input logic [7:0] wd, output int lat);
    req_wr_en = 1'b1; req_wr_data = 1'b1;
    if (with_wait) begin wait_wr_en = 1'b1; wait_wr_data = wd; end
    lat = 0;
    do begin
      @(negedge clk);
      req_wr_en = 1'b0; req_wr_data = 1'b0; wait_wr_en = 1'b0; wait_wr_data = 8'd0;
      lat++;
    end while (!fw_update_rst && lat < 100);
    check("req_rise_in_budget", 32'(fw_update_rst), 32'd1);
  endtask

  task automatic wait_rst_high();
    int i = 0;
    while (!fw_update_rst && i < 100) begin @(negedge clk); i++; end
    check("rst_rise_in_budget", 32'(fw_update_rst), 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_pulse) begin seen = 1'b1; break; end
    end
    check("done_pulse_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fw_update_rst"}, 32'(fw_update_rst), 32'd0);
    check({tag, "_wait_cycles"},   32'(wait_cycles),   32'd10);
    check({tag, "_busy"},          32'(busy),          32'd0);
    check({tag, "_done_pulse"},    32'(done_pulse),    32'd0);
    check({tag, "_err_busy_wr"},   32'(err_busy_wr),   32'd0);
    check({tag, "_err_timeout"},   32'(err_timeout),   32'd0);
    check({tag, "_fw_upd_cnt"},    32'(fw_upd_cnt),    32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int rise_base;
    int hi_cycles;

    rst_n = 1'b0;
    req_wr_en = 1'b0; req_wr_data = 1'b0;
    wait_wr_en = 1'b0; wait_wr_data = 8'd0;
    quiesce_ok = 1'b1;
    fork
      model_loop();
      cmp_loop();
    join_none

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Nominal: wait 20, request, one-cycle request level, done, count 1.
    wait_wr(8'd20);
    check("cfg_20", 32'(wait_cycles), 32'd20);
    req_measure(1'b0, 8'd0, lat);
    check("nominal_latency", 32'(lat), 32'd6);
    check("nominal_cfg_at_assert", 32'(wait_cycles), 32'd20);
    check("nominal_executed", 32'(executed), 32'd1);
    @(negedge clk);
    check("nominal_rst_fall", 32'(fw_update_rst), 32'd0);
    check("nominal_cfg_in_recover", 32'(wait_cycles), 32'd20);
    wait_done();
    check("nominal_cnt", 32'(fw_upd_cnt), 32'd1);

    // Clamp.
    wait_wr(8'd2);   check("clamp_2",   32'(wait_cycles), 32'd5);
    wait_wr(8'd0);   check("clamp_0",   32'(wait_cycles), 32'd5);
    wait_wr(8'd255); check("clamp_255", 32'(wait_cycles), 32'd255);

    // Simultaneous wait and request writes in IDLE.
    req_measure(1'b1, 8'd33, lat);
    check("simul_latency", 32'(lat), 32'd6);
    check("simul_cfg", 32'(wait_cycles), 32'd33);
    wait_done();
    check("simul_cnt", 32'(fw_upd_cnt), 32'd2);

    // Request with data 0 is ignored.
    req_wr_en = 1'b1; req_wr_data = 1'b0;
    @(negedge clk);
    req_wr_en = 1'b0;
    check("data0_busy", 32'(busy), 32'd0);
    check("data0_err", 32'(err_busy_wr), 32'd0);

    // Quiesce gating, then a restart from mid-delay.
    quiesce_ok = 1'b0;
    rise_base = n_rise;
    req_wr_en = 1'b1; req_wr_data = 1'b1;
    @(negedge clk);
    req_wr_en = 1'b0; req_wr_data = 1'b0;
    repeat (50) @(negedge clk);
    check("gate_no_rise", 32'(n_rise - rise_base), 32'd0);
    check("gate_busy", 32'(busy), 32'd1);
    quiesce_ok = 1'b1;
    repeat (2) @(negedge clk);
    quiesce_ok = 1'b0;
    @(negedge clk);
    quiesce_ok = 1'b1;
    lat = 0;
    while (!fw_update_rst && lat < 100) begin @(negedge clk); lat++; end
    check("restart_latency", 32'(lat), 32'd5);
    wait_done();
    check("gate_cnt", 32'(fw_upd_cnt), 32'd3);

    // Writes while busy in ASSERT: one error pulse, config frozen, single reset.
    boot_hold = 1'b1;
    repeat (2) @(negedge clk);
    rise_base = n_rise;
    req_wr_en = 1'b1; req_wr_data = 1'b1;
    @(negedge clk);
    req_wr_en = 1'b0; req_wr_data = 1'b0;
    wait_rst_high();
    req_wr_en = 1'b1; req_wr_data = 1'b1; wait_wr_en = 1'b1; wait_wr_data = 8'd50;
    @(negedge clk);
    req_wr_en = 1'b0; req_wr_data = 1'b0; wait_wr_en = 1'b0; wait_wr_data = 8'd0;
    check("busywr_pulse", 32'(err_busy_wr), 32'd1);
    check("busywr_cfg", 32'(wait_cycles), 32'd33);
    @(negedge clk);
    check("busywr_single", 32'(err_busy_wr), 32'd0);
    boot_hold = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("busywr_one_reset", 32'(n_rise - rise_base), 32'd1);
    check("busywr_cnt", 32'(fw_upd_cnt), 32'd4);

    // Timeout with the boot FSM parked in BOOT_WAIT.
    boot_hold = 1'b1;
    repeat (2) @(negedge clk);
    req_wr_en = 1'b1; req_wr_data = 1'b1;
    @(negedge clk);
    req_wr_en = 1'b0; req_wr_data = 1'b0;
    wait_rst_high();
    hi_cycles = 0;
    while (fw_update_rst && hi_cycles < 2000) begin hi_cycles++; @(negedge clk); end
    check("timeout_assert_cycles", 32'(hi_cycles), 32'd1024);
    check("timeout_pulse", 32'(err_timeout), 32'd1);
    check("timeout_done", 32'(done_pulse), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_cnt", 32'(fw_upd_cnt), 32'd4);
    boot_hold = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of RECOVER.
    req_wr_en = 1'b1; req_wr_data = 1'b1;
    @(negedge clk);
    req_wr_en = 1'b0; req_wr_data = 1'b0;
    wait_rst_high();
    @(negedge clk);
    check("recover_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    check("midrst_no_done", 32'(done_pulse), 32'd0);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);

    // Saturation after 256 completed updates.
    for (int i = 0; i < 256; i++) begin
      req_wr_en = 1'b1; req_wr_data = 1'b1;
      @(negedge clk);
      req_wr_en = 1'b0; req_wr_data = 1'b0;
      wait_done();
    end
    @(negedge clk);
    check("sat_cnt", 32'(fw_upd_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
